mem_arb: RTL and testbench

- Single-port memory arbiter and sequencer for the SISC unified memory.
- Shares one `dm`-style port (combinational read, clocked write) between three requesters: instruction fetch (PC path), data load/store (ALU-address path), and an external loader/DMA port.
- Replaces the direct `mm_sel` address mux.
- Drives a `stall` signal so `ctrl` freezes PC/IR while a CPU request waits.

---
 rtl/sisc_mem_pkg.sv | 9 +
 rtl/arb_prio3.sv | 16 +
 rtl/mem_arb.sv | 69 ++++++
 tb/tb_mem_arb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sisc_mem_pkg.sv
// sisc_mem_pkg: owner encoding and default widths shared by the SISC memory arbiter
package sisc_mem_pkg;
   localparam int SISC_ADDR_W = 16;
   localparam int SISC_DATA_W = 32;
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_F    = 2'd1;
   localparam logic [1:0] OWN_D    = 2'd2;
   localparam logic [1:0] OWN_X    = 2'd3;
endpackage

// File: rtl/arb_prio3.sv
// arb_prio3: three-way priority picker (data > fetch > external, external first when promoted)
module arb_prio3
   import sisc_mem_pkg::*;
(
   input  logic [2:0] req,
   input  logic [2:0] mask,
   input  logic       promote,
   output logic [1:0] nxt
);
   logic [2:0] eff;
   assign eff = req & ~mask;
   assign nxt = (promote && eff[2]) ? OWN_X :
                eff[1]              ? OWN_D :
                eff[0]              ? OWN_F :
                eff[2]              ? OWN_X : OWN_NONE;
endmodule

// File: rtl/mem_arb.sv
// mem_arb: single-port memory arbiter for fetch, data and external requesters
module mem_arb
   import sisc_mem_pkg::*;
#(
   parameter int ADDR_W    = SISC_ADDR_W,
   parameter int DATA_W    = SISC_DATA_W,
   parameter int AGE_LIMIT = 4,
   parameter int AGE_W     = 3
) (
   input  logic              clk,
   input  logic              rst_f,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   input  logic              x_req,
   input  logic              x_we,
   input  logic              x_lock,
   input  logic [ADDR_W-1:0] x_addr,
   input  logic [DATA_W-1:0] x_wdata,
   output logic              x_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] rdata,
   output logic              stall,
   output logic [1:0]        owner
);
   logic [AGE_W-1:0] age;
   logic [2:0]       req, own_oh, mask;
   logic [1:0]       pick, next_owner;
   logic             promote, burst;
   assign req     = {x_req, d_req, f_req};
   assign own_oh  = owner == OWN_F ? 3'b001 : owner == OWN_D ? 3'b010 :
                    owner == OWN_X ? 3'b100 : 3'b000;
   // a lone requester keeps the port back-to-back; otherwise the owner yields
   assign mask    = |(req & ~own_oh) ? own_oh : 3'b000;
   assign promote = age == AGE_W'(AGE_LIMIT);
   assign burst   = owner == OWN_X && x_lock && x_req;
   arb_prio3 u_prio (
      .req     (req),
      .mask    (mask),
      .promote (promote),
      .nxt     (pick)
   );
   assign next_owner = burst ? OWN_X : pick;
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         owner <= OWN_NONE;
         age   <= '0;
      end else begin
         owner <= next_owner;
         age   <= (owner == OWN_X || !x_req) ? '0 : promote ? age : age + AGE_W'(1);
      end
   end
   assign f_gnt     = owner == OWN_F;
   assign d_gnt     = owner == OWN_D;
   assign x_gnt     = owner == OWN_X;
   assign mem_addr  = f_gnt ? f_addr : d_gnt ? d_addr : x_gnt ? x_addr : '0;
   assign mem_wdata = d_gnt ? d_wdata : x_gnt ? x_wdata : '0;
   assign mem_we    = (d_gnt && d_we) || (x_gnt && x_we);
   assign rdata     = owner != OWN_NONE ? mem_rdata : '0;
   assign stall     = (f_req && !f_gnt) || (d_req && !d_gnt);
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed vectors, multi-cycle corner sequences and a randomized model check
module tb_mem_arb;
   localparam int AW = 16, DW = 32, AL = 4;
   logic clk = 0, rst_f;
   logic f_req, d_req, d_we, x_req, x_we, x_lock;
   logic [AW-1:0] f_addr, d_addr, x_addr, mem_addr;
   logic [DW-1:0] d_wdata, x_wdata, mem_wdata, mem_rdata, rdata;
   logic f_gnt, d_gnt, x_gnt, mem_we, stall;
   logic [1:0] owner;
   logic [31:0] mem [256] = '{4: 32'h88100001, default: 32'h0};
   logic [31:0] rmem [256];
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   assign mem_rdata = mem[mem_addr[7:0]];
   always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
   mem_arb #(.ADDR_W(AW), .DATA_W(DW), .AGE_LIMIT(AL), .AGE_W(3)) dut (
      .clk(clk), .rst_f(rst_f),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .x_req(x_req), .x_we(x_we), .x_lock(x_lock), .x_addr(x_addr), .x_wdata(x_wdata), .x_gnt(x_gnt),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .rdata(rdata), .stall(stall), .owner(owner)
   );
   typedef struct {
      logic f, d, dwe;
      logic [2:0] gnt;
      logic st, we;
      logic [15:0] addr;
   } vec_t;
   vec_t tv [14];
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got=%h want=%h", n, a, e);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // reference arbitration from the priority rules, independent of any encoding
   function automatic int model_next(int own, int age, bit f, bit d, bit x, bit lk);
      int order[3];
      bit r[4];
      int act;
      if (own == 3 && x && lk) return 3;
      r = '{1'b0, f, d, x};
      act = int'(f) + int'(d) + int'(x);
      if (age == AL) order = '{3, 2, 1};
      else order = '{2, 1, 3};
      foreach (order[k]) if (r[order[k]] && !(order[k] == own && act > 1)) return order[k];
      return 0;
   endfunction
   initial begin
      int first, m_own, m_age, nx;
      logic [15:0] ea;
      logic [31:0] ew;
      logic ewe;
      tv[0]  = '{1, 0, 0, 3'b000, 1, 0, 16'h0000};
      tv[1]  = '{0, 0, 0, 3'b001, 0, 0, 16'h0004};
      tv[2]  = '{1, 1, 1, 3'b000, 1, 0, 16'h0000};
      tv[3]  = '{1, 0, 1, 3'b010, 1, 1, 16'h0009};
      tv[4]  = '{0, 0, 0, 3'b001, 0, 0, 16'h0004};
      tv[5]  = '{1, 1, 0, 3'b000, 1, 0, 16'h0000};
      tv[6]  = '{1, 0, 0, 3'b010, 1, 0, 16'h0009};
      tv[7]  = '{0, 0, 0, 3'b001, 0, 0, 16'h0004};
      tv[8]  = '{1, 0, 0, 3'b000, 1, 0, 16'h0000};
      tv[9]  = '{1, 0, 0, 3'b001, 0, 0, 16'h0004};
      tv[10] = '{1, 0, 0, 3'b001, 0, 0, 16'h0004};
      tv[11] = '{1, 0, 0, 3'b001, 0, 0, 16'h0004};
      tv[12] = '{0, 0, 0, 3'b001, 0, 0, 16'h0004};
      tv[13] = '{0, 0, 0, 3'b000, 0, 0, 16'h0000};
      rst_f = 0;
      {d_req, d_we, x_req, x_we, x_lock} = '0;
      f_req = 1;
      f_addr = 16'h0004; d_addr = 16'h0009; x_addr = '0;
      d_wdata = 32'hFF000019; x_wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_owner", owner, 0);
      chk("rst_gnt", {x_gnt, d_gnt, f_gnt}, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_stall", stall, 1);
      f_req = 0;
      tick;
      rst_f = 1;
      for (int i = 0; i < 14; i++) begin
         f_req = tv[i].f; d_req = tv[i].d; d_we = tv[i].dwe;
         @(negedge clk);
         chk($sformatf("tv%0d_gnt", i), {x_gnt, d_gnt, f_gnt}, tv[i].gnt);
         chk($sformatf("tv%0d_stall", i), stall, tv[i].st);
         chk($sformatf("tv%0d_we", i), mem_we, tv[i].we);
         chk($sformatf("tv%0d_addr", i), mem_addr, tv[i].addr);
         if (tv[i].gnt == 3'b001) chk($sformatf("tv%0d_rdata", i), rdata, 32'h88100001);
         tick;
      end
      chk("store_mem9", mem[9], 32'hFF000019);
      // aging: external starved by continuous fetch/data traffic
      f_req = 1; d_req = 1; d_we = 0; x_req = 1; x_we = 0;
      first = -1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (x_gnt) begin
            first = c;
            break;
         end
         tick;
      end
      chk("age_x_gnt_cycle", first, 5);
      x_req = 0;
      tick;
      @(negedge clk);
      chk("age_cleared", dut.age, 0);
      f_req = 0; d_req = 0;
      tick;
      tick;
      // locked external burst while data waits
      x_req = 1; x_lock = 1; x_we = 1; x_addr = 16'h0010; x_wdata = 32'hA0000000;
      tick;
      for (int i = 0; i < 5; i++) begin
         x_addr = 16'(16'h0010 + i); x_wdata = 32'hA0000000 + i;
         d_req = 1; d_we = 0; d_addr = 16'h0009;
         x_lock = i < 4; x_req = i < 4;
         @(negedge clk);
         chk($sformatf("burst%0d_xgnt", i), x_gnt, 1);
         chk($sformatf("burst%0d_dgnt", i), d_gnt, 0);
         chk($sformatf("burst%0d_stall", i), stall, 1);
         chk($sformatf("burst%0d_addr", i), mem_addr, 16'h0010 + i);
         tick;
      end
      @(negedge clk);
      chk("burst_after_dgnt", d_gnt, 1);
      chk("burst_after_xgnt", x_gnt, 0);
      d_req = 0; x_we = 0;
      tick;
      for (int i = 0; i < 5; i++) chk($sformatf("burst_mem%0d", i), mem[16 + i], 32'hA0000000 + i);
      tick;
      // reset in the middle of a data store
      d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 32'hDEADBEEF;
      tick;
      #2;
      chk("rst_mid_pre_we", mem_we, 1);
      rst_f = 0;
      #1;
      chk("rst_mid_we", mem_we, 0);
      chk("rst_mid_owner", owner, 0);
      d_req = 0;
      tick;
      rst_f = 1;
      chk("rst_mid_nowrite", mem[32], 0);
      // randomized traffic against the reference model
      m_own = 0; m_age = 0;
      rmem = mem;
      for (int c = 0; c < 300; c++) begin
         f_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1));
         x_req = 1'($urandom_range(0, 1)); x_lock = $urandom_range(0, 3) != 0;
         d_we = 1'($urandom_range(0, 1)); x_we = 1'($urandom_range(0, 1));
         f_addr = 16'($urandom_range(0, 255)); d_addr = 16'($urandom_range(0, 255));
         x_addr = 16'($urandom_range(0, 255));
         d_wdata = $urandom; x_wdata = $urandom;
         @(negedge clk);
         ea  = m_own == 1 ? f_addr : m_own == 2 ? d_addr : m_own == 3 ? x_addr : 16'h0;
         ew  = m_own == 2 ? d_wdata : m_own == 3 ? x_wdata : 32'h0;
         ewe = (m_own == 2 && d_we) || (m_own == 3 && x_we);
         chk($sformatf("rnd%0d_owner", c), owner, m_own);
         chk($sformatf("rnd%0d_gnt", c), {x_gnt, d_gnt, f_gnt}, {m_own == 3, m_own == 2, m_own == 1});
         chk($sformatf("rnd%0d_stall", c), stall, (f_req && m_own != 1) || (d_req && m_own != 2));
         chk($sformatf("rnd%0d_we", c), mem_we, ewe);
         chk($sformatf("rnd%0d_addr", c), mem_addr, ea);
         chk($sformatf("rnd%0d_wdata", c), mem_wdata, ew);
         chk($sformatf("rnd%0d_rdata", c), rdata, m_own != 0 ? rmem[ea[7:0]] : 32'h0);
         if (ewe) rmem[ea[7:0]] = ew;
         nx = model_next(m_own, m_age, f_req, d_req, x_req, x_lock);
         m_age = (m_own == 3 || !x_req) ? 0 : (m_age < AL ? m_age + 1 : AL);
         m_own = nx;
         tick;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
